// File: rtl/ptw_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ptw_arbiter                                                |
// | Description : Round-robin share of one page-table walker between the    |
// |               I-TLB and D-TLB miss paths, with same-page merge and       |
// |               re-issue of walks that straddle a ptbr change.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ptw_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int RETRY_W        = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BUS_DATA_WIDTH-1:0]   ptbr,
  input  logic                        i_req,
  input  logic [BUS_DATA_WIDTH-1:0]   i_vaddr,
  output logic                        i_done,
  input  logic                        d_req,
  input  logic [BUS_DATA_WIDTH-1:0]   d_vaddr,
  output logic                        d_done,
  output logic [8*BUS_DATA_WIDTH-1:0] pte_line,
  output logic                        busy,
  output logic [RETRY_W-1:0]          retry_cnt,
  output logic                        walk_enable,
  output logic [BUS_DATA_WIDTH-1:0]   walk_vaddr,
  output logic [BUS_DATA_WIDTH-1:0]   walk_ptbr,
  input  logic                        walk_ready,
  input  logic [8*BUS_DATA_WIDTH-1:0] walk_pte_array
);

  localparam int LINE_W = 8 * BUS_DATA_WIDTH;
  localparam int VPN_HI = 47;
  localparam int VPN_LO = 12;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_ARM     = 3'd2,
    S_WALK    = 3'd3,
    S_DELIVER = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      owner_d_q, owner_d_d;   // 1: D-side owns the walk
  logic                      last_d_q, last_d_d;     // 1: D-side was served last
  logic [BUS_DATA_WIDTH-1:0] walk_vaddr_q, walk_vaddr_d;
  logic [BUS_DATA_WIDTH-1:0] walk_ptbr_q, walk_ptbr_d;
  logic [LINE_W-1:0]         pte_line_q, pte_line_d;
  logic [RETRY_W-1:0]        retry_q, retry_d;
  logic                      walk_enable_q, walk_enable_d;
  logic                      i_done_q, i_done_d;
  logic                      d_done_q, d_done_d;
  logic                      busy_q, busy_d;

  logic                      pick_d;
  logic                      other_req;
  logic [BUS_DATA_WIDTH-1:0] other_vaddr;
  logic                      merge;

  // Next-state and registered-output computation for the walk sequencer.
  always_comb begin
    state_d       = state_q;
    owner_d_d     = owner_d_q;
    last_d_d      = last_d_q;
    walk_vaddr_d  = walk_vaddr_q;
    walk_ptbr_d   = walk_ptbr_q;
    pte_line_d    = pte_line_q;
    retry_d       = retry_q;
    walk_enable_d = 1'b0;
    i_done_d      = 1'b0;
    d_done_d      = 1'b0;
    pick_d        = 1'b0;
    other_req     = owner_d_q ? i_req : d_req;
    other_vaddr   = owner_d_q ? i_vaddr : d_vaddr;
    merge         = other_req &&
                    (other_vaddr[VPN_HI:VPN_LO] == walk_vaddr_q[VPN_HI:VPN_LO]);

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          // With both pending, the side not served last wins.
          pick_d        = (i_req && d_req) ? ~last_d_q : d_req;
          owner_d_d     = pick_d;
          walk_vaddr_d  = pick_d ? d_vaddr : i_vaddr;
          walk_ptbr_d   = ptbr;
          walk_enable_d = 1'b1;
          state_d       = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_ARM;
      end
      S_ARM: begin
        // A ready left over from an earlier walk must fall before we trust it.
        if (!walk_ready) begin
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        if (walk_ready) begin
          if (ptbr != walk_ptbr_q) begin
            walk_ptbr_d   = ptbr;
            walk_enable_d = 1'b1;
            if (retry_q != {RETRY_W{1'b1}}) begin
              retry_d = retry_q + RETRY_W'(1);
            end
            state_d = S_LAUNCH;
          end else begin
            pte_line_d = walk_pte_array;
            i_done_d   = owner_d_q ? merge : 1'b1;
            d_done_d   = owner_d_q ? 1'b1 : merge;
            state_d    = S_DELIVER;
          end
        end
      end
      S_DELIVER: begin
        last_d_d = owner_d_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset also returns the walker interface to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_d_q     <= 1'b0;
      last_d_q      <= 1'b0;
      walk_vaddr_q  <= '0;
      walk_ptbr_q   <= '0;
      pte_line_q    <= '0;
      retry_q       <= '0;
      walk_enable_q <= 1'b0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_d_q     <= owner_d_d;
      last_d_q      <= last_d_d;
      walk_vaddr_q  <= walk_vaddr_d;
      walk_ptbr_q   <= walk_ptbr_d;
      pte_line_q    <= pte_line_d;
      retry_q       <= retry_d;
      walk_enable_q <= walk_enable_d;
      i_done_q      <= i_done_d;
      d_done_q      <= d_done_d;
      busy_q        <= busy_d;
    end
  end

  assign i_done      = i_done_q;
  assign d_done      = d_done_q;
  assign pte_line    = pte_line_q;
  assign busy        = busy_q;
  assign retry_cnt   = retry_q;
  assign walk_enable = walk_enable_q;
  assign walk_vaddr  = walk_vaddr_q;
  assign walk_ptbr   = walk_ptbr_q;

  // The owning requester must keep its miss asserted while its walk is in flight.
  a_owner_hold: assert property (@(posedge clk) disable iff (reset)
    (state_q inside {S_LAUNCH, S_ARM, S_WALK}) |-> (owner_d_q ? d_req : i_req));

endmodule
`default_nettype wire
